// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one full-subtractor
// stage per cycle with a registered borrow, behind a start/done handshake.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb;
   logic             bin;
   logic [CW-1:0]    count;
   logic             load, last, d_bit, bout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      last     = (count == CW'(WIDTH - 1));
      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      d_bit = sa[0] ^ sb[0] ^ bin;
      bout  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
   end

   // diff/borrow are only written while shifting, so they hold across IDLE/DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa     <= '0;
         sb     <= '0;
         bin    <= 1'b0;
         count  <= '0;
         diff   <= '0;
         borrow <= 1'b0;
      end else if (load) begin
         sa    <= a;
         sb    <= b;
         bin   <= 1'b0;
         count <= '0;
      end else if (busy) begin
         sa    <= sa >> 1;
         sb    <= sb >> 1;
         bin   <= bout;
         diff  <= {d_bit, diff[WIDTH-1:1]};
         count <= count + CW'(1);
         if (last) borrow <= bout;
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): driver pushes expected
// results from an arithmetic model, a negedge monitor pops them on done.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, borrow;
   logic [W-1:0] diff;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      int           issue;
   } exp_t;

   exp_t expq[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   bit   sim_end = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   function automatic exp_t model(input int unsigned x, input int unsigned y, input int c);
      exp_t e;
      int   r;
      r     = int'(x) - int'(y);
      e.d   = W'(r & 'hFF);
      e.br  = (x < y);
      e.issue = c;
      return e;
   endfunction

   task automatic check(input string name, input int act, input int req);
      vectors = vectors + 1;
      if (act != req) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!sim_end && !rst) begin
         if (done && busy) check("done_and_busy", 1, 0);
         if (done) begin
            if (expq.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = expq.pop_front();
               check("diff", int'(diff), int'(e.d));
               check("borrow", int'(borrow), int'(e.br));
               check("latency", cyc - e.issue, W + 1);
            end
         end
      end
   end

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n = n + 1;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      expq.push_back(model(x, y, cyc));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
      issue(x, y);
      wait_done();
   endtask

   initial begin
      // reset state
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_diff", int'(diff), 0);
      check("rst_borrow", int'(borrow), 0);
      rst = 1'b0;

      // directed cases
      run_op(8'd5, 8'd3);
      run_op(8'd3, 8'd5);
      run_op(8'd0, 8'd1);
      run_op(8'hFF, 8'hFF);
      run_op(8'h80, 8'h7F);
      run_op(8'h00, 8'h00);
      run_op(8'hFF, 8'h00);

      // start and operand changes while busy are ignored
      issue(8'd100, 8'd42);
      @(negedge clk);
      @(negedge clk);
      a = 8'hAA; b = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 8'h01; b = 8'hF0;
      wait_done();
      // restart in the cycle right after done (run_op drives on the next negedge)
      run_op(8'd7, 8'd9);
      run_op(8'd9, 8'd7);

      // reset four cycles into SHIFT
      issue(8'h55, 8'h22);
      repeat (3) @(negedge clk);
      check("mid_busy", int'(busy), 1);
      rst = 1'b1;
      #1;
      expq.delete();
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_diff", int'(diff), 0);
      check("mid_rst_borrow", int'(borrow), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (W + 4) @(negedge clk);
      check("post_rst_idle_diff", int'(diff), 0);
      run_op(8'h55, 8'h22);

      // randomised pairs with random idle gaps
      for (int i = 0; i < 200; i++) begin
         logic [W-1:0] x, y;
         x = W'($urandom_range(0, 255));
         y = W'($urandom_range(0, 255));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(x, y);
      end

      repeat (4) @(negedge clk);
      check("queue_drained", expq.size(), 0);
      sim_end = 1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
